ssd_scan_driver: RTL and testbench

//   Consumes the divided slow clock from the clock-divider stage and uses it as a scan tick.

---
 rtl/ssd_scan_driver.sv | 116 +++++++++++
 tb/tb_ssd_scan_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver; sclk is sampled as data and edge-detected.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module ssd_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IdxW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic [IdxW-1:0]       digit_idx
);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick;
  logic                   last;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [4*DIGITS-1:0]    snap_q, snap_d;
  logic [DIGITS-1:0]      anode_d;
  logic [6:0]             seg_d;

  assign tick      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign last      = (idx_q == IdxW'(DIGITS - 1));
  assign digit_idx = idx_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;

  // blank[i] is set when nibble i and every nibble above it are zero
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (snap_q[4*i +: 4] == 4'h0);
      blank[i]   = zero_above;
    end
  end
`endif

  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    if (en && tick) begin
      idx_d = last ? '0 : idx_q + IdxW'(1);
    end
    // Snapshot only refreshes on a wrap while scanning, so a frame never tears
    if (!en || (tick && last)) begin
      snap_d = value;
    end
  end

  always_comb begin
    anode_d = '1;
    seg_d   = 7'h7F;
    if (en) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IdxW'(i)) begin
          anode_d[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
          seg_d = blank[i] ? 7'h7F : hex7(snap_q[4*i +: 4]);
`else
          seg_d = hex7(snap_q[4*i +: 4]);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      idx_q  <= '0;
      snap_q <= '0;
      anode  <= '1;
      seg    <= 7'h7F;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sclk};
      prev_q <= sync_q[SYNC_STAGES-1];
      idx_q  <= idx_d;
      snap_q <= snap_d;
      anode  <= anode_d;
      seg    <= seg_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: directed scenarios plus random traffic vs a reference model.
module tb_ssd_scan_driver;
  localparam int unsigned D    = 4;
  localparam int unsigned S    = 2;
  localparam int unsigned IdxW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sclk = 1'b0;
  logic            en = 1'b0;
  logic [4*D-1:0]  value = '0;
  logic [D-1:0]    anode;
  logic [6:0]      seg;
  logic [IdxW-1:0] digit_idx;

  int checks = 0;
  int failures = 0;

  ssd_scan_driver #(.DIGITS(D), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .en        (en),
    .value     (value),
    .anode     (anode),
    .seg       (seg),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZSeg = 7'h7F;
  localparam bit         LzBlank = 1'b1;
`else
  localparam logic [6:0] ZSeg = 7'h40;
  localparam bit         LzBlank = 1'b0;
`endif

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: sclk sample history, integer index, snapshot, expected outputs
  logic [S:0]     m_hist = '0;
  int             m_idx = 0;
  logic [4*D-1:0] m_snap = '0;
  logic [D-1:0]   e_anode = '1;
  logic [6:0]     e_seg = 7'h7F;

  wire            m_tick  = m_hist[S-1] & ~m_hist[S];
  wire            m_wrap  = m_tick & en & (m_idx == D - 1);
  wire [4*D-1:0]  m_upper = m_snap >> (4 * m_idx);
  wire            m_blank = LzBlank && (m_idx > 0) && (m_upper == '0);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hist  <= '0;
      m_idx   <= 0;
      m_snap  <= '0;
      e_anode <= '1;
      e_seg   <= 7'h7F;
    end else begin
      m_hist <= {m_hist[S-1:0], sclk};
      if (m_tick && en) m_idx <= (m_idx + 1) % D;
      if (!en || m_wrap) m_snap <= value;
      e_anode <= en ? ~(D'(1) << m_idx) : '1;
      e_seg   <= (!en || m_blank) ? 7'h7F : dec_tab[m_upper[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("model_anode", 32'(anode), 32'(e_anode));
      chk("model_seg", 32'(seg), 32'(e_seg));
      chk("model_idx", 32'(digit_idx), 32'(m_idx));
    end
  endtask

  task automatic expect_out(input string tag, input logic [D-1:0] a, input logic [6:0] s,
                            input int idx);
    chk({tag, "_anode"}, 32'(anode), 32'(a));
    chk({tag, "_seg"}, 32'(seg), 32'(s));
    chk({tag, "_idx"}, 32'(digit_idx), 32'(idx));
  endtask

  task automatic pulse();
    sclk = 1'b1;
    step(3);
    sclk = 1'b0;
    step(3);
  endtask

  initial begin
    @(negedge clk);
    // Reset with sclk toggling
    for (int i = 0; i < 3; i++) begin
      sclk = ~sclk;
      step(1);
      expect_out("reset", 4'hF, 7'h7F, 0);
    end
    sclk  = 1'b0;
    step(2);
    rst_n = 1'b1;
    value = 16'h1234;
    step(2);
    en = 1'b1;
    step(1);
    expect_out("scan0", 4'hE, 7'h19, 0);
    pulse(); expect_out("scan1", 4'hD, 7'h30, 1);
    pulse(); expect_out("scan2", 4'hB, 7'h24, 2);
    pulse(); expect_out("scan3", 4'h7, 7'h79, 3);
    pulse(); expect_out("wrap", 4'hE, 7'h19, 0);

    // Value change mid-frame must not tear
    pulse(); expect_out("tear1", 4'hD, 7'h30, 1);
    value = 16'hFFFF;
    pulse(); expect_out("tear2", 4'hB, 7'h24, 2);
    pulse(); expect_out("tear3", 4'h7, 7'h79, 3);
    pulse(); expect_out("new0", 4'hE, 7'h0E, 0);
    pulse(); expect_out("new1", 4'hD, 7'h0E, 1);
    pulse(); expect_out("new2", 4'hB, 7'h0E, 2);

    // Blank and resume
    en = 1'b0;
    step(1);
    expect_out("blank", 4'hF, 7'h7F, 2);
    value = 16'hABCD;
    step(2);
    expect_out("blank_hold", 4'hF, 7'h7F, 2);
    en = 1'b1;
    step(1);
    expect_out("resume", 4'hB, 7'h03, 2);

    // Held-high sclk ticks once; index moves at S+1, outputs at S+2
    sclk = 1'b1;
    step(S + 1);
    expect_out("lat_before", 4'hB, 7'h03, 3);
    step(1);
    expect_out("lat_after", 4'h7, 7'h08, 3);
    step(100);
    expect_out("held_high", 4'h7, 7'h08, 3);
    sclk = 1'b0;
    step(3);

    // Leading zeros
    en    = 1'b0;
    value = 16'h0005;
    step(1);
    en = 1'b1;
    step(1);
    expect_out("lz3a", 4'h7, ZSeg, 3);
    pulse(); expect_out("lz0", 4'hE, 7'h12, 0);
    pulse(); expect_out("lz1", 4'hD, ZSeg, 1);
    pulse(); expect_out("lz2", 4'hB, ZSeg, 2);
    pulse(); expect_out("lz3", 4'h7, ZSeg, 3);

    // Mid-scan reset
    rst_n = 1'b0;
    step(1);
    expect_out("midreset", 4'hF, 7'h7F, 0);
    rst_n = 1'b1;
    step(2);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) sclk = ~sclk;
      if ($urandom_range(31) == 0) en = ~en;
      if ($urandom_range(15) == 0) value = 16'($urandom);
      if ($urandom_range(7) == 0) value = 16'($urandom_range(255));
      rst_n = ($urandom_range(299) != 0);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
